// File: rtl/spi_reg_pkg.sv
// Shared constants, state type and address helper for the SPI register controller.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

  // Counter value 17 marks a frame that ran past FRAME_BITS.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT} state_e;

  // True when addr is at or below the configured top of the register map.
  function automatic logic addr_in_map(input logic [6:0] addr, input int unsigned max_addr);
    return 32'(addr) <= max_addr;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchroniser with rise/fall pulse detection.
// SYNC_STAGES must be at least 2.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one delayed copy of the synced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that writes the five PWM configuration registers.
// Optional read-back over cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [15:0]      shift_q;
  logic             frame_start, frame_eval;
  logic             do_write, do_err;
  logic [6:0]       frame_addr;
  logic [7:0]       frame_data;
  logic [7:0]       en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;
  logic             wr_pulse_q, frame_err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_HIGH;
    else     state_q <= state_d;
  end

  // Next state; WAIT_HIGH drops any frame already in flight at reset release.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_eval  = 1'b0;
    case (state_q)
      WAIT_HIGH: if (ncs_lvl) state_d = IDLE;
      IDLE: begin
        if (ncs_fall) begin
          state_d     = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d    = IDLE;
          frame_eval = 1'b1;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  // Shift register and saturating bit counter; an sclk rise coincident with ncs rise is dropped
  // because the synced ncs level is already high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (frame_start) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == SHIFT && sclk_rise && !ncs_lvl) begin
      shift_q <= {shift_q[14:0], copi_lvl};
      if (bit_cnt_q != CNT_OVF) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign do_write   = frame_eval && (bit_cnt_q == CNT_FULL) && shift_q[15] &&
                      addr_in_map(frame_addr, MAX_ADDR);
  assign do_err     = frame_eval && (bit_cnt_q != CNT_FULL);

  // Configuration registers, updated on the edge after the ncs rise is detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
    end else if (do_write) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_out_lo_q <= frame_data;
        ADDR_EN_OUT_HI: en_out_hi_q <= frame_data;
        ADDR_EN_PWM_LO: en_pwm_lo_q <= frame_data;
        ADDR_EN_PWM_HI: en_pwm_hi_q <= frame_data;
        ADDR_PWM_DUTY:  duty_q      <= frame_data;
        default: ;
      endcase
    end
  end

  // Single-cycle status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_pulse_q  <= do_write;
      frame_err_q <= do_err;
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_pulse        = wr_pulse_q;
  assign frame_err       = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [7:0] rd_mux, rd_data_q;
  logic       rd_loaded_q, cipo_q;

  // Register selected by the address bits once the first byte has been shifted in.
  always_comb begin
    rd_mux = 8'h00;
    if (addr_in_map(shift_q[6:0], MAX_ADDR)) begin
      case (shift_q[6:0])
        ADDR_EN_OUT_LO: rd_mux = en_out_lo_q;
        ADDR_EN_OUT_HI: rd_mux = en_out_hi_q;
        ADDR_EN_PWM_LO: rd_mux = en_pwm_lo_q;
        ADDR_EN_PWM_HI: rd_mux = en_pwm_hi_q;
        ADDR_PWM_DUTY:  rd_mux = duty_q;
        default:        rd_mux = 8'h00;
      endcase
    end
  end

  // Latch the read data after bit 8, then present one bit per sclk fall, MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q   <= '0;
      rd_loaded_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (state_q != SHIFT || ncs_rise) begin
      rd_data_q   <= '0;
      rd_loaded_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (!rd_loaded_q) begin
      if (bit_cnt_q == CNT_W'(8) && !shift_q[7]) begin
        rd_data_q   <= rd_mux;
        rd_loaded_q <= 1'b1;
      end
    end else if (sclk_fall) begin
      cipo_q    <= rd_data_q[7];
      rd_data_q <= {rd_data_q[6:0], 1'b0};
    end
  end

  assign cipo = cipo_q;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};
`else
  assign cipo = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed plan plus random frames against a register model.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse, frame_err;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;
  int err_seen = 0;

  logic [7:0] model [5];
  logic [7:0] rd_obs;

  spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count strobe-high cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_pulse)  wr_seen  <= wr_seen + 1;
    if (frame_err) err_seen <= err_seen + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_lo"}, 16'(en_reg_out_7_0),  16'(model[0]));
    check({tag, ".out_hi"}, 16'(en_reg_out_15_8), 16'(model[1]));
    check({tag, ".pwm_lo"}, 16'(en_reg_pwm_7_0),  16'(model[2]));
    check({tag, ".pwm_hi"}, 16'(en_reg_pwm_15_8), 16'(model[3]));
    check({tag, ".duty"},   16'(pwm_duty_cycle),  16'(model[4]));
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    #80 sclk = 1'b1;
    #80 sclk = 1'b0;
  endtask

  // Full transaction of n bits taken MSB first from data; n=17 appends one extra zero bit.
  task automatic frame(input string tag, input logic [15:0] data, input int n);
    logic [16:0] bits;
    int          wr0, err0;
    logic        exp_wr, exp_err;
    logic [7:0]  exp_rd;
    logic [6:0]  addr;
    bits = (n == 17) ? {data, 1'b0} : 17'(data >> (16 - n));
    addr = data[14:8];
    wr0  = wr_seen;
    err0 = err_seen;
    rd_obs = 8'h00;
    ncs = 1'b0;
    #200;
    for (int i = n - 1; i >= 0; i--) begin
      int p;
      p = n - 1 - i;
      copi = bits[i];
      #80;
      if (n == 16 && p >= 8) rd_obs[15 - p] = cipo;
      sclk = 1'b1;
      #80 sclk = 1'b0;
    end
    #80 copi = 1'b0;
    #120 ncs = 1'b1;
    #300;
    @(negedge clk);
    // Reference: only complete 16-bit write frames to mapped addresses change state.
    exp_err = (n != 16);
    exp_wr  = (n == 16) && data[15] && (addr <= 7'd4);
    exp_rd  = 8'h00;
`ifdef SPI_READBACK_EN
    if (addr <= 7'd4) exp_rd = model[addr];
`endif
    if (exp_wr) model[addr] = data[7:0];
    check({tag, ".wr_pulse"}, 16'(wr_seen - wr0), exp_wr ? 16'd1 : 16'd0);
    check({tag, ".frame_err"}, 16'(err_seen - err0), exp_err ? 16'd1 : 16'd0);
    if (n == 16 && !data[15]) check({tag, ".cipo"}, 16'(rd_obs), 16'(exp_rd));
    check_regs(tag);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;

    // Reset state.
    #23;
    check_regs("reset");
    check("reset.cipo", 16'(cipo), 16'd0);
    check("reset.strobes", {14'd0, wr_pulse, frame_err}, 16'd0);
    @(negedge clk) rst = 1'b0;
    #100;

    frame("w_duty", 16'h8480, 16);
    frame("w_outhi", 16'h81F0, 16);
    frame("w_addr5", 16'h85FF, 16);
    frame("r_duty", 16'h0400, 16);
    frame("len12", 16'h8123, 12);
    frame("len17", 16'h8456, 17);
    frame("len0", 16'h8000, 0);

    // Reset mid-frame, released with ncs still low.
    ncs = 1'b0;
    #200;
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h80 >> i));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check_regs("midrst");
    check("midrst.cipo", 16'(cipo), 16'd0);
    check("midrst.strobes", {14'd0, wr_pulse, frame_err}, 16'd0);
    @(negedge clk) rst = 1'b0;
    wr0 = wr_seen;
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h11 >> i));
    #80 ncs = 1'b1;
    #300;
    @(negedge clk);
    check("midrst.no_wr", 16'(wr_seen - wr0), 16'd0);
    check_regs("midrst.after");
    frame("w_pwmlo", 16'h8233, 16);

`ifdef SPI_READBACK_EN
    frame("w_outlo", 16'h80A5, 16);
    frame("r_outlo", 16'h0000, 16);
    frame("r_addr7f", 16'h7F00, 16);
`endif

    // Random frames, mostly well-formed, some short or long.
    for (int k = 0; k < 24; k++) begin
      logic [15:0] d;
      int          sel, n;
      d = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      sel = $urandom_range(0, 5);
      n = (sel == 4) ? 15 : (sel == 5) ? 17 : 16;
      frame($sformatf("rand%0d", k), d, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
